// File: rtl/spi_trig_pkg.sv
// Shared command codes and control-word bit positions for the SPI pattern
// trigger / capture slave.
package spi_trig_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] CMD_DATA   = 3'd0;
  localparam logic [CODE_W-1:0] CMD_CTRL   = 3'd1;
  localparam logic [CODE_W-1:0] CMD_MASK   = 3'd2;
  localparam logic [CODE_W-1:0] CMD_PAT    = 3'd3;
  localparam logic [CODE_W-1:0] CMD_OFFSET = 3'd4;
  localparam logic [CODE_W-1:0] CMD_POST   = 3'd5;
  localparam logic [CODE_W-1:0] CMD_READ   = 3'd6;
  localparam logic [CODE_W-1:0] CMD_RSVD   = 3'd7;

  localparam int CTRL_ARM  = 0;
  localparam int CTRL_EDGE = 1;

endpackage

// File: rtl/spi_frame_rx.sv
// SPI frame deserialiser: 3-bit code then DATA_W value bits, MSB first.
// SS low at any edge returns the bit counter to the code phase.
module spi_frame_rx
  import spi_trig_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int BIT_W  = $clog2(CODE_W + DATA_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ss,
  input  logic              mosi,
  output logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] code_now,
  output logic              code_strobe,
  output logic              code_valid,
  output logic [BIT_W-1:0]  bit_idx,
  output logic [DATA_W-1:0] value,
  output logic              frame_done
);

  localparam int FRAME_LEN = CODE_W + DATA_W;
  localparam logic [BIT_W-1:0] LAST      = BIT_W'(FRAME_LEN - 1);
  localparam logic [BIT_W-1:0] CODE_LAST = BIT_W'(CODE_W - 1);

  logic [BIT_W-1:0]  cnt;
  logic [DATA_W-1:0] sh;

  // code_now/value include the bit being sampled on this edge
  assign code_now    = {sh[CODE_W-2:0], mosi};
  assign value       = {sh[DATA_W-2:0], mosi};
  assign code_strobe = ss && (cnt == CODE_LAST);
  assign frame_done  = ss && (cnt == LAST);
  assign code_valid  = (cnt > CODE_LAST);
  assign bit_idx     = cnt - BIT_W'(CODE_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      sh   <= '0;
      code <= '0;
    end else if (!ss) begin
      cnt <= '0;
    end else begin
      sh  <= value;
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      if (code_strobe) code <= code_now;
    end
  end

endmodule

// File: rtl/spi_trigger_capture.sv
// SPI-slave masked pattern trigger with offset/edge qualification and a
// circular pre/post-trigger capture buffer read back over MISO.
module spi_trigger_capture
  import spi_trig_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic SCLK,
  input  logic RSTN,
  input  logic SS,
  input  logic MOSI,
  output logic MISO,
  output logic TRIG,
  output logic DONE
);

  localparam int BIT_W = $clog2(CODE_W + DATA_W);
  localparam int SEL_W = $clog2(DATA_W);

  logic [CODE_W-1:0] code, code_now;
  logic              code_strobe, code_valid, frame_done;
  logic [BIT_W-1:0]  bit_idx;
  logic [DATA_W-1:0] value;

  spi_frame_rx #(.DATA_W(DATA_W), .BIT_W(BIT_W)) u_rx (
    .clk        (SCLK),
    .rst_n      (RSTN),
    .ss         (SS),
    .mosi       (MOSI),
    .code       (code),
    .code_now   (code_now),
    .code_strobe(code_strobe),
    .code_valid (code_valid),
    .bit_idx    (bit_idx),
    .value      (value),
    .frame_done (frame_done)
  );

  logic [DATA_W-1:0] mask, mask_d, pattern, pattern_d, prev, prev_d;
  logic [CNT_W-1:0]  offset, offset_d, post, post_d;
  logic [CNT_W-1:0]  offset_cnt, offset_cnt_d, post_cnt, post_cnt_d, post_inc;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_d, rd_ptr, rd_ptr_d, wr_next;
  logic              armed, armed_d, edge_en, edge_en_d;
  logic              trig, trig_d, done, done_d, miso, miso_d;
  logic              wr_en, cmp_en, match;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic [SEL_W-1:0]  rd_sel;

  assign rd_word  = mem[rd_ptr];
  // bit to present after sampling value bit bit_idx is the next lower one
  assign rd_sel   = SEL_W'(BIT_W'(DATA_W - 2) - bit_idx);
  assign wr_next  = wr_ptr + 1'b1;
  assign post_inc = post_cnt + 1'b1;
  assign cmp_en   = armed && !trig && (offset_cnt >= offset);
  assign match    = (((value ^ pattern) & mask) == '0) &&
                    (!edge_en || (((value ^ prev) & mask) != '0));

  always_comb begin
    mask_d       = mask;
    pattern_d    = pattern;
    offset_d     = offset;
    post_d       = post;
    offset_cnt_d = offset_cnt;
    post_cnt_d   = post_cnt;
    wr_ptr_d     = wr_ptr;
    rd_ptr_d     = rd_ptr;
    prev_d       = prev;
    armed_d      = armed;
    edge_en_d    = edge_en;
    trig_d       = trig;
    done_d       = done;
    wr_en        = 1'b0;
    if (frame_done) begin
      case (code)
        CMD_DATA: if (!done) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_next;
          prev_d   = value;
          if (armed && offset_cnt != '1) offset_cnt_d = offset_cnt + 1'b1;
          if (cmp_en) begin
            if (match) begin
              trig_d     = 1'b1;
              post_cnt_d = '0;
              if (post == '0) begin
                done_d   = 1'b1;
                rd_ptr_d = wr_next;
              end
            end
          end else if (trig) begin
            post_cnt_d = post_inc;
            if (post_inc == post) begin
              done_d   = 1'b1;
              rd_ptr_d = wr_next;
            end
          end
        end
        CMD_CTRL: begin
          armed_d   = value[CTRL_ARM];
          edge_en_d = value[CTRL_EDGE];
          if (value[CTRL_ARM]) begin
            trig_d       = 1'b0;
            done_d       = 1'b0;
            offset_cnt_d = '0;
            post_cnt_d   = '0;
          end
        end
        CMD_MASK:   mask_d    = value;
        CMD_PAT:    pattern_d = value;
        CMD_OFFSET: offset_d  = value[CNT_W-1:0];
        CMD_POST:   post_d    = value[CNT_W-1:0];
        CMD_READ:   rd_ptr_d  = rd_ptr + 1'b1;
        CMD_RSVD:   ;
        default:    ;
      endcase
    end
    // MISO carries the status level unless a READ value bit is due next
    miso_d = trig_d;
    if (SS) begin
      if (code_strobe && code_now == CMD_READ)
        miso_d = rd_word[DATA_W-1];
      else if (code_valid && code == CMD_READ && !frame_done)
        miso_d = rd_word[rd_sel];
    end
  end

  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      mask       <= '0;
      pattern    <= '0;
      offset     <= '0;
      post       <= '0;
      offset_cnt <= '0;
      post_cnt   <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      prev       <= '0;
      armed      <= 1'b0;
      edge_en    <= 1'b0;
      trig       <= 1'b0;
      done       <= 1'b0;
      miso       <= 1'b0;
    end else begin
      mask       <= mask_d;
      pattern    <= pattern_d;
      offset     <= offset_d;
      post       <= post_d;
      offset_cnt <= offset_cnt_d;
      post_cnt   <= post_cnt_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      prev       <= prev_d;
      armed      <= armed_d;
      edge_en    <= edge_en_d;
      trig       <= trig_d;
      done       <= done_d;
      miso       <= miso_d;
    end
  end

  // capture storage carries no reset; contents are meaningless until written
  always_ff @(posedge SCLK) begin
    if (wr_en) mem[wr_ptr] <= value;
  end

  assign MISO = miso;
  assign TRIG = trig;
  assign DONE = done;

endmodule
